// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC accumulator slice.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int N_DEF     = 10;
    localparam int ACC_W_DEF = 2 * N_DEF + 8;
    localparam int LEN_W_DEF = 8;

    // Largest value representable in a w-bit signed accumulator.
    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a w-bit signed accumulator.
    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / block-sum-out handshake bundle of the MAC accumulator.
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [2*N-1:0]     in_prod;
    logic [LEN_W-1:0]   len;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_ovf;

    modport master (
        output in_valid, in_prod, len, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, len, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/mac_accumulator_sat_add.sv
// Signed add with clamping to the ACC_W-bit range; sat_o flags a clamp.
module sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [ACC_W-1:0] add_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    sat_o
);
    localparam logic signed [ACC_W:0] MAX_W = (ACC_W + 1)'(acc_max(ACC_W));
    localparam logic signed [ACC_W:0] MIN_W = (ACC_W + 1)'(acc_min(ACC_W));

    logic signed [ACC_W:0] wide;

    // One extra bit holds the exact sum so the range test cannot wrap.
    always_comb begin
        wide  = (ACC_W + 1)'(acc_i) + (ACC_W + 1)'(add_i);
        sum_o = wide[ACC_W-1:0];
        sat_o = 1'b0;
        if (wide > MAX_W) begin
            sum_o = MAX_W[ACC_W-1:0];
            sat_o = 1'b1;
        end else if (wide < MIN_W) begin
            sum_o = MIN_W[ACC_W-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/mac_accumulator.sv
// Block accumulator: sums len signed products with saturation and presents
// the result on a registered valid/ready output.
//
//   state   | meaning
//   IDLE    | no block in progress, waiting for the first product
//   ACC     | block started, more products expected
//   HOLD    | block sum presented on out_sum until out_ready
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    mac_accumulator_if.slave   bus
);
    state_e                  state_q, state_d;
    logic                    run_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
    logic                    ovf_q, ovf_d;
    logic                    out_ovf_q, out_ovf_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    sat;
    logic [LEN_W-1:0]        len_eff;
    logic [LEN_W-1:0]        cnt_inc;
    logic                    accept;
    logic                    start;
    logic                    add;

    assign prod     = bus.in_prod;
    assign prod_ext = ACC_W'(prod);
    assign len_eff  = (bus.len == '0) ? LEN_W'(1) : bus.len;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign accept   = bus.in_valid && bus.in_ready;
    // A product accepted outside ACC always opens a new block (IDLE, or HOLD
    // when the previous sum leaves in the same cycle).
    assign start    = accept && (state_q != ST_ACC);
    assign add      = accept && (state_q == ST_ACC);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .acc_i (acc_q),
        .add_i (prod_ext),
        .sum_o (sum_sat),
        .sat_o (sat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; clear overrides everything but reset.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = (len_eff == LEN_W'(1)) ? ST_HOLD : ST_ACC;
                ST_ACC:  if (accept && (cnt_inc == len_q)) state_d = ST_HOLD;
                ST_HOLD: begin
                    if (accept)              state_d = (len_eff == LEN_W'(1)) ? ST_HOLD : ST_ACC;
                    else if (bus.out_ready)  state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs; run_q keeps in_ready low until the first clock after reset.
    always_comb begin
        bus.in_ready  = run_q && !clear && ((state_q != ST_HOLD) || bus.out_ready);
        bus.out_valid = (state_q == ST_HOLD);
    end

    assign bus.out_sum = out_sum_q;
    assign bus.out_ovf = out_ovf_q;

    // Datapath next values: block start, accumulate step, or abort.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (start) begin
            acc_d = prod_ext;
            cnt_d = LEN_W'(1);
            len_d = len_eff;
            ovf_d = 1'b0;
            if (len_eff == LEN_W'(1)) begin
                out_sum_d = prod_ext;
                out_ovf_d = 1'b0;
            end
        end else if (add) begin
            acc_d = sum_sat;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sat;
            if (cnt_inc == len_q) begin
                out_sum_d = sum_sat;
                out_ovf_d = ovf_q | sat;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (ACC_W=28 and ACC_W=21) share one
// stimulus stream; a block-level model checks every cycle.
module tb_mac_accumulator;
    localparam int N     = 10;
    localparam int LEN_W = 8;
    localparam int AW_A  = 28;
    localparam int AW_B  = 21;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [2*N-1:0]   in_prod = '0;
    logic [LEN_W-1:0] len = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.N(N), .ACC_W(AW_A), .LEN_W(LEN_W)) bus_a ();
    mac_accumulator_if #(.N(N), .ACC_W(AW_B), .LEN_W(LEN_W)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_prod   = in_prod;
    assign bus_a.len       = len;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_prod   = in_prod;
    assign bus_b.len       = len;
    assign bus_b.out_ready = out_ready;

    mac_accumulator #(.N(N), .ACC_W(AW_A), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a)
    );
    mac_accumulator #(.N(N), .ACC_W(AW_B), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (block level) ----------------
    typedef struct {
        longint sa;
        logic   oa;
        longint sb;
        logic   ob;
    } res_t;

    res_t   expq[$];
    longint blk[$];
    int     blk_len;
    bit     run = 1'b0;

    function automatic void block_sum(input int w, output longint s, output logic o);
        longint mx;
        longint mn;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -mx - 1;
        s  = blk[0];
        o  = 1'b0;
        for (int i = 1; i < blk.size(); i++) begin
            s = s + blk[i];
            if (s > mx) begin s = mx; o = 1'b1; end
            else if (s < mn) begin s = mn; o = 1'b1; end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) run = 1'b0;
        else        run = 1'b1;
    end

    always @(negedge clk) begin : monitor
        bit   er;
        bit   ev;
        res_t r;
        if (!rst_n) begin
            check("rst_in_ready_a", bus_a.in_ready, 0);
            check("rst_out_valid_a", bus_a.out_valid, 0);
            check("rst_in_ready_b", bus_b.in_ready, 0);
            check("rst_out_valid_b", bus_b.out_valid, 0);
            expq.delete();
            blk.delete();
        end else begin
            ev = (expq.size() != 0);
            er = run && !clear && (!ev || out_ready);
            check("in_ready_a", bus_a.in_ready, er);
            check("in_ready_b", bus_b.in_ready, er);
            check("out_valid_a", bus_a.out_valid, ev);
            check("out_valid_b", bus_b.out_valid, ev);
            if (ev) begin
                check("out_sum_a", $signed(bus_a.out_sum), expq[0].sa);
                check("out_ovf_a", bus_a.out_ovf, expq[0].oa);
                check("out_sum_b", $signed(bus_b.out_sum), expq[0].sb);
                check("out_ovf_b", bus_b.out_ovf, expq[0].ob);
            end
            if (clear) begin
                expq.delete();
                blk.delete();
            end else begin
                if (ev && out_ready) void'(expq.pop_front());
                if (in_valid && er) begin
                    if (blk.size() == 0) blk_len = (len == 0) ? 1 : int'(len);
                    blk.push_back(longint'($signed(in_prod)));
                    if (blk.size() == blk_len) begin
                        block_sum(AW_A, r.sa, r.oa);
                        block_sum(AW_B, r.sb, r.ob);
                        expq.push_back(r);
                        blk.delete();
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [LEN_W-1:0]      len;
        int                    n;
        logic [3:0][2*N-1:0]   p;
        longint                sa;
        logic                  oa;
        longint                sb;
        logic                  ob;
    } vec_t;

    // Presents one product and returns #1 after the edge that accepts it.
    task automatic push(input logic [2*N-1:0] p, input logic [LEN_W-1:0] l);
        in_valid = 1'b1;
        in_prod  = p;
        len      = l;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL push_timeout: product %0h never accepted", p);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input vec_t v, input string tag);
        for (int k = 0; k < v.n; k++) push(v.p[k], v.len);
        check({tag, "_valid"}, bus_a.out_valid, 1);
        check({tag, "_sum_a"}, $signed(bus_a.out_sum), v.sa);
        check({tag, "_ovf_a"}, bus_a.out_ovf, v.oa);
        check({tag, "_sum_b"}, $signed(bus_b.out_sum), v.sb);
        check({tag, "_ovf_b"}, bus_b.out_ovf, v.ob);
        @(posedge clk); #1;
    endtask

    vec_t vecs[5];
    vec_t two_ones;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vecs[0] = '{8'd4, 4, {20'd4, 20'd3, 20'd2, 20'd1},          10, 1'b0, 10, 1'b0};
        vecs[1] = '{8'd2, 2, {20'd0, 20'd0, 20'd3, 20'hFFFFB},      -2, 1'b0, -2, 1'b0};
        vecs[2] = '{8'd4, 4, {4{20'h40000}},                   1048576, 1'b0, 1048575, 1'b1};
        vecs[3] = '{8'd1, 1, {20'd0, 20'd0, 20'd0, 20'd7},           7, 1'b0, 7, 1'b0};
        vecs[4] = '{8'd0, 1, {20'd0, 20'd0, 20'd0, 20'd9},           9, 1'b0, 9, 1'b0};
        two_ones = '{8'd2, 2, {20'd0, 20'd0, 20'd1, 20'd1},          2, 1'b0, 2, 1'b0};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum_a", bus_a.out_sum, 0);
        check("reset_ovf_a", bus_a.out_ovf, 0);
        check("reset_sum_b", bus_b.out_sum, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", bus_a.in_ready, 1);

        // Table vectors.
        for (int i = 0; i < 5; i++) send_block(vecs[i], $sformatf("vec%0d", i));

        // Backpressure with len=1: pending product must wait, then swap in one cycle.
        out_ready = 1'b0;
        push(20'd11, 8'd1);
        in_valid = 1'b1;
        in_prod  = 20'd22;
        len      = 8'd1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", bus_a.in_ready, 0);
            check("bp_sum_stable", $signed(bus_a.out_sum), 11);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus_a.in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", bus_a.out_valid, 1);
        check("bp_next_sum", $signed(bus_a.out_sum), 22);
        @(posedge clk); #1;

        // Asynchronous reset mid-block.
        push(20'd1, 8'd4);
        push(20'd1, 8'd4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rst_valid", bus_a.out_valid, 0);
        check("abort_rst_ready", bus_a.in_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(two_ones, "after_rst");

        // Synchronous clear mid-block; the product offered with clear is dropped.
        push(20'd5, 8'd4);
        push(20'd5, 8'd4);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_prod  = 20'd99;
        len      = 8'd1;
        @(negedge clk);
        check("clear_ready", bus_a.in_ready, 0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_valid", bus_a.out_valid, 0);
        send_block(two_ones, "after_clear");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       in_prod = ($urandom_range(0, 1) != 0) ? 20'h7FFFF : 20'h80000;
                1:       in_prod = 20'($urandom_range(0, 16)) - 20'd8;
                default: in_prod = 20'($urandom());
            endcase
            len       = 8'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the combinational Booth multiplier (`multiplier`, N=10).
- Accepts a stream of signed 2N-bit products over a valid/ready handshake and accumulates a block of `len` products into a wider saturating accumulator.
- Presents the block sum on a valid/ready output.
- Forms the MAC/dot-product stage of the arithmetic datapath.

Parameters:
- N, 10, multiplier operand width; product width is 2N.
- ACC_W, 2*N+8, accumulator/output width, signed.
- LEN_W, 8, width of the block-length input.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort; returns the block to IDLE.
- len  in  LEN_W  products per block; sampled on the first accepted product; 0 treated as 1.
- in_valid  in  1  product valid.
- in_ready  out  1  product accepted when in_valid && in_ready.
- in_prod  in  2N  signed two's-complement product (multiplier `result`); multiplier `carry_out` is not consumed.
- out_valid  out  1  block sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  ACC_W  saturated signed block sum, registered.
- out_ovf  out  1  sticky: at least one saturation occurred in this block.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc, cnt, len_q, out_sum, out_ovf = 0; out_valid = 0.
  - in_ready = 0 while rst_n=0, 1 from the first cycle after release.
- States: IDLE, ACC, HOLD. in_ready = (state!=HOLD) || out_ready. out_valid = (state==HOLD).
- IDLE, on accept:
  - len_q = (len==0) ? 1 : len; acc = sext(in_prod); cnt = 1; ovf = 0.
  - Next state HOLD if len_q==1, else ACC.
- ACC, on accept:
  - acc = sat(acc + sext(in_prod)); cnt++.
  - When the incremented cnt == len_q, go to HOLD. No accept: hold state.
- Saturation:
  - Sum is computed in ACC_W+1 bits.
  - Result > 2^(ACC_W-1)-1 clamps to max; result < -2^(ACC_W-1) clamps to min. Either case sets ovf.
  - ovf is sticky until the next block start.
- HOLD:
  - out_sum/out_ovf are stable; no accumulation.
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=1 with in_valid=1: the sum is emitted and the new product starts a new block in the same cycle (IDLE-accept rules apply, next state ACC/HOLD). Gives zero-bubble throughput.
- Latency: out_valid rises on the cycle after the last product of a block is accepted. Sustained throughput is 1 product/cycle.
- Outputs are registered. out_sum is updated only on entry to HOLD and holds its value until the next HOLD entry.
- clear (synchronous):
  - Highest priority after reset: state=IDLE, acc=0, cnt=0, out_valid=0, ovf=0.
  - Any product presented that cycle is not accepted (in_ready=0 during clear).
- Reset or clear mid-block discards the partial sum. The following block is independent.
- len changes while in ACC/HOLD are ignored (len_q is latched).
- Inputs are don't-care when in_valid=0. The block never drops an accepted product.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE/ACC/HOLD);
  - default N/ACC_W/LEN_W localparams;
  - functions acc_max/acc_min(ACC_W).
- One combinational sub-module, sat_add:
  - parameterized by ACC_W;
  - inputs acc, sign-extended addend;
  - outputs sum and sat flag.
  - Instantiated once.
- Top module holds the FSM, counter and registers.

Test Plan:
- len=4, products 1,2,3,4 back-to-back, out_ready=1 → out_valid one cycle after the 4th accept, out_sum=10, out_ovf=0.
- len=2, products 0xFFFFB (−5), 0x00003 (+3) → out_sum=0xFFFFFFE (−2, ACC_W=28), out_ovf=0.
- ACC_W=21, len=4, product 0x40000 (262144 = −512·−512) four times → out_sum=0x0FFFFF (1048575), out_ovf=1. Next block, len=1, product 7 → out_sum=7, out_ovf=0.
- Backpressure, len=1:
  - out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, out_sum stable.
  - Then out_ready=1 → old sum emitted and next product accepted in the same cycle; no product lost or duplicated (scoreboard).
- len=0, product 9 → treated as len=1, out_sum=9 next cycle.
- Mid-block abort, len=4, two products accepted:
  - rst_n pulsed low asynchronously → out_valid=0, in_ready=0 during reset; after release, len=2, products 1,1 → out_sum=2.
  - Repeat with clear=1 for one cycle instead of reset → same result.
